// File: rtl/cdb_arbiter.sv
// cdb_arbiter: round-robin arbiter sharing one common-data-bus completion
// port among NUM_REQ functional units. The winning payload is registered and
// broadcast one cycle after the grant; a flush suppresses grants that cycle.
// Optional build macro CDB_PERF_EN adds per-unit grant counters and a
// conflict-cycle counter; arbitration is identical with or without it.
module cdb_arbiter #(
  parameter int NUM_REQ   = 5,
  parameter int ROB_IDX_W = 4,
  parameter int DATA_W    = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         flush,
  input  logic [NUM_REQ-1:0]           req_valid,
  input  logic [NUM_REQ*ROB_IDX_W-1:0] req_rob_idx,
  input  logic [NUM_REQ*DATA_W-1:0]    req_data,
  output logic [NUM_REQ-1:0]           req_ready,
  output logic                         cdb_valid,
  output logic [ROB_IDX_W-1:0]         cdb_rob_idx,
  output logic [DATA_W-1:0]            cdb_data,
  output logic [NUM_REQ-1:0]           cdb_src
`ifdef CDB_PERF_EN
  ,
  output logic [NUM_REQ*32-1:0]        perf_grant_cnt,
  output logic [31:0]                  perf_conflict_cnt
`endif
);

  localparam int PTR_W = $clog2(NUM_REQ);

  // Highest-priority requester for the current cycle.
  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] grant;
  logic [PTR_W-1:0]   grant_idx;
  logic               found;
  logic [PTR_W:0]     scan_sum;
  logic [PTR_W-1:0]   scan_idx;
  logic [PTR_W-1:0]   next_ptr;

  // Round-robin scan starting at ptr with explicit compare-and-wrap.
  always_comb begin
    // NOTE: every variable gets a default first so no path leaves it unassigned and infers a latch.
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    scan_sum  = '0;
    scan_idx  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      scan_sum = {1'b0, ptr} + (PTR_W+1)'(k);
      if (scan_sum >= (PTR_W+1)'(NUM_REQ)) begin
        scan_sum = scan_sum - (PTR_W+1)'(NUM_REQ);
      end
      scan_idx = scan_sum[PTR_W-1:0];
      if (!found && req_valid[scan_idx]) begin
        found           = 1'b1;
        grant[scan_idx] = 1'b1;
        grant_idx       = scan_idx;
      end
    end
    // Flush and reset both suppress every grant.
    if (flush || !rst) begin
      grant = '0;
    end
  end

  assign req_ready = grant;

  // Pointer moves one past the winner, wrapping the last unit back to 0.
  always_comb begin
    if (grant_idx == PTR_W'(NUM_REQ - 1)) begin
      next_ptr = '0;
    end else begin
      next_ptr = grant_idx + PTR_W'(1);
    end
  end

  // Broadcast register and priority pointer update.
  always_ff @(posedge clk or negedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so all registers sample pre-edge values.
    if (!rst) begin
      ptr         <= '0;
      cdb_valid   <= 1'b0;
      cdb_rob_idx <= '0;
      cdb_data    <= '0;
      cdb_src     <= '0;
    end else if (|grant) begin
      ptr         <= next_ptr;
      cdb_valid   <= 1'b1;
      cdb_rob_idx <= req_rob_idx[grant_idx*ROB_IDX_W +: ROB_IDX_W];
      cdb_data    <= req_data[grant_idx*DATA_W +: DATA_W];
      cdb_src     <= grant;
    end else begin
      cdb_valid   <= 1'b0;
      cdb_src     <= '0;
    end
  end

`ifdef CDB_PERF_EN
  // Saturating per-unit grant counters and multi-requester conflict counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      perf_grant_cnt    <= '0;
      perf_conflict_cnt <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i] && (perf_grant_cnt[i*32 +: 32] != 32'hFFFF_FFFF)) begin
          perf_grant_cnt[i*32 +: 32] <= perf_grant_cnt[i*32 +: 32] + 32'd1;
        end
      end
      if (!flush && ($countones(req_valid) > 1) && (perf_conflict_cnt != 32'hFFFF_FFFF)) begin
        perf_conflict_cnt <= perf_conflict_cnt + 32'd1;
      end
    end
  end
`else
  // Counters are not built; the datapath above is unchanged.
`endif

endmodule

// File: tb/tb_cdb_arbiter.sv
// Directed testbench for cdb_arbiter: a per-cycle vector table for the
// rotation, wrap, flush and single-requester cases, plus hand sequences for
// reset, the DEAD_BEEF payload case, asynchronous reset mid-broadcast and
// (when CDB_PERF_EN is defined) the performance counters.
module tb_cdb_arbiter;
  localparam int N  = 5;
  localparam int RW = 4;
  localparam int DW = 32;

  logic            clk;
  logic            rst;
  logic            flush;
  logic [N-1:0]    req_valid;
  logic [N*RW-1:0] req_rob_idx;
  logic [N*DW-1:0] req_data;
  logic [N-1:0]    req_ready;
  logic            cdb_valid;
  logic [RW-1:0]   cdb_rob_idx;
  logic [DW-1:0]   cdb_data;
  logic [N-1:0]    cdb_src;
`ifdef CDB_PERF_EN
  logic [N*32-1:0] perf_grant_cnt;
  logic [31:0]     perf_conflict_cnt;
`endif

  cdb_arbiter #(.NUM_REQ(N), .ROB_IDX_W(RW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .flush       (flush),
    .req_valid   (req_valid),
    .req_rob_idx (req_rob_idx),
    .req_data    (req_data),
    .req_ready   (req_ready),
    .cdb_valid   (cdb_valid),
    .cdb_rob_idx (cdb_rob_idx),
    .cdb_data    (cdb_data),
    .cdb_src     (cdb_src)
`ifdef CDB_PERF_EN
    ,
    .perf_grant_cnt    (perf_grant_cnt),
    .perf_conflict_cnt (perf_conflict_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One table row: inputs applied for a cycle, req_ready expected that
  // cycle, and cdb_* expected during that cycle (result of previous grant).
  typedef struct {
    logic [N-1:0]  valid;
    logic          flush;
    logic [N-1:0]  exp_ready;
    logic          exp_cv;
    logic [N-1:0]  exp_src;
    logic [RW-1:0] exp_tag;
  } vec_t;

  vec_t vecs[18];

  // Unit i carries tag i+1 and data 0x1111*(i+1).
  task automatic set_default_payload();
    for (int i = 0; i < N; i++) begin
      req_rob_idx[i*RW +: RW] = RW'(i + 1);
      req_data[i*DW +: DW]    = DW'(32'h1111 * (i + 1));
    end
  endtask

  // Leaves the bench 1 time unit after a rising edge with reset released.
  task automatic do_reset();
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = '0;
    @(posedge clk);
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  initial begin
    // Rows: valid, flush, ready, cdb_valid, cdb_src, cdb_rob_idx
    vecs[0]  = '{5'b11111, 1'b0, 5'b00001, 1'b0, 5'b00000, 4'd0};
    vecs[1]  = '{5'b11111, 1'b0, 5'b00010, 1'b1, 5'b00001, 4'd1};
    vecs[2]  = '{5'b11111, 1'b0, 5'b00100, 1'b1, 5'b00010, 4'd2};
    vecs[3]  = '{5'b11111, 1'b0, 5'b01000, 1'b1, 5'b00100, 4'd3};
    vecs[4]  = '{5'b11111, 1'b0, 5'b10000, 1'b1, 5'b01000, 4'd4};
    vecs[5]  = '{5'b11111, 1'b0, 5'b00001, 1'b1, 5'b10000, 4'd5};
    vecs[6]  = '{5'b11111, 1'b0, 5'b00010, 1'b1, 5'b00001, 4'd1};
    vecs[7]  = '{5'b00000, 1'b0, 5'b00000, 1'b1, 5'b00010, 4'd2};
    vecs[8]  = '{5'b10001, 1'b0, 5'b10000, 1'b0, 5'b00000, 4'd2};
    vecs[9]  = '{5'b10001, 1'b0, 5'b00001, 1'b1, 5'b10000, 4'd5};
    vecs[10] = '{5'b00011, 1'b0, 5'b00010, 1'b1, 5'b00001, 4'd1};
    vecs[11] = '{5'b00011, 1'b1, 5'b00000, 1'b1, 5'b00010, 4'd2};
    vecs[12] = '{5'b00011, 1'b0, 5'b00001, 1'b0, 5'b00000, 4'd2};
    vecs[13] = '{5'b00011, 1'b0, 5'b00010, 1'b1, 5'b00001, 4'd1};
    vecs[14] = '{5'b01000, 1'b0, 5'b01000, 1'b1, 5'b00010, 4'd2};
    vecs[15] = '{5'b01000, 1'b0, 5'b01000, 1'b1, 5'b01000, 4'd4};
    vecs[16] = '{5'b00000, 1'b0, 5'b00000, 1'b1, 5'b01000, 4'd4};
    vecs[17] = '{5'b00000, 1'b0, 5'b00000, 1'b0, 5'b00000, 4'd4};

    // Reset state, with requests present to show req_ready is gated.
    rst       = 1'b0;
    flush     = 1'b0;
    req_valid = 5'b11111;
    set_default_payload();
    #3;
    check("reset_ready", 64'(req_ready), 64'(5'b00000));
    check("reset_cdb_valid", 64'(cdb_valid), 64'd0);
    check("reset_cdb_rob_idx", 64'(cdb_rob_idx), 64'd0);
    check("reset_cdb_data", 64'(cdb_data), 64'd0);
    check("reset_cdb_src", 64'(cdb_src), 64'd0);

    // Single request from unit 2 with a distinctive payload.
    do_reset();
    req_rob_idx[2*RW +: RW] = 4'd3;
    req_data[2*DW +: DW]    = 32'hDEAD_BEEF;
    req_valid = 5'b00100;
    #4;
    check("u2_ready", 64'(req_ready), 64'(5'b00100));
    @(posedge clk);
    #1;
    req_valid = 5'b11111;
    check("u2_cdb_valid", 64'(cdb_valid), 64'd1);
    check("u2_cdb_rob_idx", 64'(cdb_rob_idx), 64'd3);
    check("u2_cdb_data", 64'(cdb_data), 64'hDEAD_BEEF);
    check("u2_cdb_src", 64'(cdb_src), 64'(5'b00100));
    #3;
    // ptr is now 3, so unit 3 leads when everyone asks.
    check("u2_ptr_is_3", 64'(req_ready), 64'(5'b01000));
    set_default_payload();

    // Table-driven cycle sequence from a fresh reset.
    do_reset();
    for (int v = 0; v < 18; v++) begin
      req_valid = vecs[v].valid;
      flush     = vecs[v].flush;
      #4;
      check($sformatf("vec%0d_ready", v), 64'(req_ready), 64'(vecs[v].exp_ready));
      check($sformatf("vec%0d_cdb_valid", v), 64'(cdb_valid), 64'(vecs[v].exp_cv));
      check($sformatf("vec%0d_cdb_src", v), 64'(cdb_src), 64'(vecs[v].exp_src));
      check($sformatf("vec%0d_cdb_rob_idx", v), 64'(cdb_rob_idx), 64'(vecs[v].exp_tag));
      check($sformatf("vec%0d_cdb_data", v), 64'(cdb_data),
            64'(DW'(32'h1111 * int'(vecs[v].exp_tag))));
      @(posedge clk);
      #1;
    end
    flush = 1'b0;

    // Asynchronous reset while a broadcast is on the bus.
    do_reset();
    req_valid = 5'b11111;
    @(posedge clk);
    #1;
    check("midrst_before_valid", 64'(cdb_valid), 64'd1);
    #1 rst = 1'b0;
    #1;
    check("midrst_cdb_valid", 64'(cdb_valid), 64'd0);
    check("midrst_cdb_src", 64'(cdb_src), 64'd0);
    check("midrst_cdb_data", 64'(cdb_data), 64'd0);
    check("midrst_ready", 64'(req_ready), 64'd0);
    @(posedge clk);
    #1 rst = 1'b1;
    #3;
    check("midrst_first_grant", 64'(req_ready), 64'(5'b00001));
    @(posedge clk);
    #1;
    check("midrst_after_cdb_src", 64'(cdb_src), 64'(5'b00001));

`ifdef CDB_PERF_EN
    // Two contending units for 10 cycles: alternate grants, 10 conflicts.
    do_reset();
    req_valid = 5'b00011;
    for (int c = 0; c < 10; c++) begin
      @(posedge clk);
      #1;
    end
    req_valid = 5'b00000;
    @(posedge clk);
    #1;
    check("perf_grant_0", 64'(perf_grant_cnt[0*32 +: 32]), 64'd5);
    check("perf_grant_1", 64'(perf_grant_cnt[1*32 +: 32]), 64'd5);
    check("perf_grant_2", 64'(perf_grant_cnt[2*32 +: 32]), 64'd0);
    check("perf_conflict", 64'(perf_conflict_cnt), 64'd10);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/cdb_arbiter.md
Name: cdb_arbiter

Overview:
- Round-robin arbiter sharing one common-data-bus (CDB) completion port among NUM_REQ functional units (alu, mul, div, load, store).
- Winning payload is registered and broadcast to the ROB commit-mark port, the reservation stations and the register file.
- Sits between the functional-unit result stages and the rob_queue commit inputs.
- Flush-aware: a flush kills any pending broadcast.

Parameters:
- NUM_REQ, 5, number of requesting functional units, range 2..8
- ROB_IDX_W, 4, width of the ROB entry tag
- DATA_W, 32, width of the result payload

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- flush  in  1  pipeline flush from commit; synchronous effect
- req_valid  in  NUM_REQ  per-unit result valid
- req_rob_idx  in  NUM_REQ*ROB_IDX_W  per-unit ROB tag; unit i occupies bits [i*ROB_IDX_W +: ROB_IDX_W]
- req_data  in  NUM_REQ*DATA_W  per-unit result; unit i occupies bits [i*DATA_W +: DATA_W]
- req_ready  out  NUM_REQ  one-hot grant; transfer occurs when req_valid[i] and req_ready[i] are both high
- cdb_valid  out  1  broadcast valid
- cdb_rob_idx  out  ROB_IDX_W  broadcast ROB tag
- cdb_data  out  DATA_W  broadcast result
- cdb_src  out  NUM_REQ  one-hot source unit of the current broadcast

Behaviour:
- Reset (rst low, asynchronous):
  - cdb_valid=0, cdb_rob_idx=0, cdb_data=0, cdb_src=0, ptr=0.
  - req_ready is combinational from inputs, so it is 0 while rst is low.
- State:
  - ptr, width $clog2(NUM_REQ), range 0..NUM_REQ-1: the highest-priority requester.
  - Output register holding cdb_* values.
- Grant (combinational, same cycle):
  - Scan i = ptr, ptr+1, ..., wrapping modulo NUM_REQ (explicit compare-and-wrap, not a power-of-two mask).
  - The first i with req_valid[i]=1 gets req_ready[i]=1; all other bits are 0.
  - req_ready is never high for a requester whose req_valid is low.
  - When flush=1, req_ready=0 for all units.
- Latency: a request granted in cycle N appears on cdb_* in cycle N+1, with cdb_valid high for exactly one cycle per grant.
- Update on a cycle with a grant to unit g:
  - cdb_valid<=1, cdb_rob_idx<=req_rob_idx[g], cdb_data<=req_data[g], cdb_src<=one-hot(g).
  - ptr<=g+1, wrapping NUM_REQ-1 to 0.
- No grant: cdb_valid<=0 and cdb_src<=0; cdb_rob_idx and cdb_data hold; ptr holds.
- Throughput: one broadcast per cycle. Back-to-back grants give continuous cdb_valid.
- Requester contract:
  - A requester whose valid is not accepted holds its valid and payload stable until granted.
  - The arbiter does not latch losing requests.
- Fairness:
  - A continuously-valid requester is granted within NUM_REQ cycles.
  - With all units valid, grants rotate 0,1,...,NUM_REQ-1,0.
- Flush:
  - In the flush cycle there are no grants and cdb_valid<=0 next cycle. A broadcast already on cdb_* during the flush cycle is still driven that cycle.
  - ptr holds.
- Single requester: it is granted every cycle it is valid, whatever ptr is.
- Reset mid-broadcast: cdb_valid drops immediately (asynchronously), and the in-flight result is lost.

Optional Feature:
- Macro CDB_PERF_EN.
- Defined, the block adds:
  - output perf_grant_cnt (NUM_REQ*32): per-unit grant counters;
  - output perf_conflict_cnt (32): counts cycles where more than one req_valid was high and flush was low.
  - Both counters reset to 0 on rst, saturate at 32'hFFFF_FFFF, do not clear on flush, and have no effect on arbitration.
- Undefined: the ports and counters are absent. Arbitration timing is identical either way.

Test Plan:
- Reset, then req_valid=5'b00100 with rob_idx=3 and data=32'hDEAD_BEEF -> req_ready=5'b00100 same cycle; next cycle cdb_valid=1, cdb_rob_idx=3, cdb_data=32'hDEAD_BEEF, cdb_src=5'b00100, ptr=3.
- From reset, hold req_valid=5'b11111 for 7 cycles -> grant sequence 0,1,2,3,4,0,1; cdb_valid continuously high from cycle 2.
- ptr=4 and req_valid=5'b10001 for two cycles -> grant 4 then 0; ptr wraps 4->0->1.
- Assert flush with req_valid=5'b00011 -> req_ready=0 that cycle; next cycle cdb_valid=0 and ptr unchanged. After flush drops, unit at ptr-order first is granted.
- Drop rst mid-stream while cdb_valid=1 -> cdb_valid=0 before the next clock edge; after release, the first grant goes to unit 0 priority order.
- With CDB_PERF_EN: 10 cycles of req_valid=5'b00011 -> perf_grant_cnt[0]=5, perf_grant_cnt[1]=5, perf_conflict_cnt=10.
